// File: rtl/mant_mul_pkg.sv
// Shared constants and FSM state type for the shift-and-add mantissa multiplier.
package mant_mul_pkg;
  localparam int WIDTH  = 24;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_48bit.sv
// Plain unsigned adder used for the multiplier's accumulate step; wraps modulo 2^W.
module adder_48bit #(
  parameter int W = 48
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule

// File: rtl/mant_mul_ctrl.sv
// Sequential shift-and-add mantissa multiplier with valid/ready handshakes on both sides.
// Optional build macro MANT_MUL_EARLY_TERM_EN stops RUN once the remaining multiplier bits are zero.
module mant_mul_ctrl #(
  parameter int WIDTH  = mant_mul_pkg::WIDTH,
  parameter int PROD_W = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic              busy
);
  import mant_mul_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   sum;
  logic [WIDTH-1:0]    mplier_shr;
  logic                run_last;

  adder_48bit #(.W(PROD_W)) u_acc_add (
    .a_i   (acc_q),
    .b_i   (mcand_q),
    .sum_o (sum)
  );

  assign mplier_shr = mplier_q >> 1;

`ifdef MANT_MUL_EARLY_TERM_EN
  // Once the shifted multiplier is empty, later cycles could only add zero.
  assign run_last = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_shr == '0);
`else
  assign run_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d    = '0;
          mcand_d  = {{(PROD_W - WIDTH){1'b0}}, in_a};
          mplier_d = in_b;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (mplier_q[0]) acc_d = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + 1'b1;
        if (run_last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_prod = acc_q;
endmodule

// File: doc/mant_mul_ctrl.md
MANT_MUL_CTRL -- requirements
Module: mant_mul_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the mantissa operand width including the hidden bit.
REQ-002 The block SHALL have parameter PROD_W, default 2*WIDTH (48), giving the product width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-007 The block SHALL have port in_a, input, WIDTH bits: multiplicand mantissa.
REQ-008 The block SHALL have port in_b, input, WIDTH bits: multiplier mantissa.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_prod holds a finished product.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-011 The block SHALL have port out_prod, output, PROD_W bits: unsigned product in_a*in_b.
REQ-012 The block SHALL have port busy, output, 1 bit: the FSM is in RUN.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in RUN; out_valid SHALL be 1 only in DONE.
REQ-015 An input handshake (in_valid && in_ready at a rising edge) SHALL load acc=0, mcand={0,in_a}, mplier=in_b and cnt=0, then enter RUN.
REQ-016 The block SHALL ignore in_valid, in_a and in_b outside IDLE; operands need not be held after the handshake.
REQ-017 Each RUN cycle SHALL set acc=acc+mcand when mplier[0]=1 (add modulo 2^PROD_W), then shift mcand left by 1, shift mplier right by 1, and increment cnt.
REQ-018 RUN SHALL exit to DONE on the edge where cnt reaches WIDTH-1, i.e. 24 RUN cycles.
REQ-019 Latency from the input handshake edge to out_valid=1 SHALL be exactly 24 clock cycles when WIDTH=24 and early termination is off.
REQ-020 DONE SHALL hold out_valid=1 and a stable out_prod until out_ready=1 at a rising edge, then return to IDLE; there is no timeout.
REQ-021 in_ready SHALL first re-assert the cycle after the output handshake; input and output handshakes never coincide.
REQ-022 out_prod SHALL be driven from acc in all states; its value is defined only while out_valid=1.
REQ-023 Zero operands SHALL need no special-casing; the result is 0 through the normal path.
REQ-024 The product SHALL never overflow, since PROD_W=2*WIDTH.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, acc=0, mcand=0, mplier=0 and cnt=0, regardless of clock.
REQ-026 During reset the outputs SHALL be in_ready=1, out_valid=0, busy=0 and out_prod=0.
REQ-027 Reset asserted mid-RUN or mid-DONE SHALL discard the operation silently, with no out_valid pulse.

Configuration
REQ-028 Macro MANT_MUL_EARLY_TERM_EN, when defined, SHALL make RUN exit to DONE on the first edge where the shifted mplier becomes 0 or cnt reaches WIDTH-1, whichever is earlier.
REQ-029 With MANT_MUL_EARLY_TERM_EN defined, latency SHALL be max(1, index of the highest set bit of in_b + 1) cycles: in_b=0 or in_b=1 gives 1 cycle.
REQ-030 With MANT_MUL_EARLY_TERM_EN undefined, latency SHALL be fixed at WIDTH cycles; the product is identical in both builds.

Structure
REQ-031 Package mant_mul_pkg SHALL hold the WIDTH and PROD_W constants and the state enum typedef (IDLE/RUN/DONE).
REQ-032 The accumulator add SHALL be done by one instance of the existing adder_48bit sub-module; no other sub-modules are allowed.

Verification
REQ-033 Bench: in_a=0xC00000, in_b=0xC00000 -> out_prod=0x900000000000, out_valid exactly 24 cycles after accept (early-term off).
REQ-034 Bench: in_a=0xFFFFFF, in_b=0xFFFFFF -> out_prod=0xFFFFFE000001.
REQ-035 Bench: in_a=0x800000, in_b=0x800000 with out_ready held 0 for 10 cycles -> out_valid and out_prod=0x400000000000 stable throughout; in_ready=1 one cycle after release.
REQ-036 Bench: in_b=0x000001, in_a=0x123456 with MANT_MUL_EARLY_TERM_EN -> out_prod=0x123456 after 1 cycle; without the macro -> same value after 24 cycles.
REQ-037 Bench: rst_n pulsed low at RUN cycle 10 -> out_valid never asserts, in_ready=1 during reset, next operation (3*5) yields 0x00000000000F.
REQ-038 Bench: in_valid toggling with new operands during RUN -> ignored, result matches the originally accepted pair.
